// File: rtl/pixel_array_pkg.sv
// Shared types and constants for the pixel array frame sequencer.
// State encoding, the dead-cycle length between phases and the ramp/timer widths.
package pixel_array_pkg;

  typedef enum logic [2:0] {
    IDLE,
    ERASE,
    GAP,
    EXPOSE,
    CONVERT,
    READ
  } state_t;

  localparam int GAP_LEN = 1;
  localparam int RAMP_W  = 8;
  localparam int TIMER_W = 9;

  function automatic int row_width(input int height);
    return (height > 1) ? $clog2(height) : 1;
  endfunction

endpackage

// File: rtl/pixel_array_ctrl_if.sv
// Host-side requests and array-side controls of the frame sequencer.
// master is the sequencer; slave is whoever drives requests and consumes the controls.
interface pixel_array_ctrl_if
  import pixel_array_pkg::*;
#(
  parameter int PIXEL_ARRAY_HEIGHT = 2
);
  localparam int ROW_W = row_width(PIXEL_ARRAY_HEIGHT);

  logic                          start;
  logic                          continuous;
  logic                          abort;
  logic [7:0]                    expose_cycles;
  logic                          erase;
  logic                          expose;
  logic                          convert;
  logic [PIXEL_ARRAY_HEIGHT-1:0] read;
  logic [RAMP_W-1:0]             pixel_counter;
  logic                          row_valid;
  logic [ROW_W-1:0]              row_index;
  logic                          busy;
  logic                          frame_done;

  modport master (
    input  start, continuous, abort, expose_cycles,
    output erase, expose, convert, read, pixel_counter,
           row_valid, row_index, busy, frame_done
  );

  modport slave (
    output start, continuous, abort, expose_cycles,
    input  erase, expose, convert, read, pixel_counter,
           row_valid, row_index, busy, frame_done
  );

endinterface

// File: rtl/phase_timer.sv
// Loadable down-counter timing one phase; last is high on the phase's final cycle.
// last_next predicts last one cycle ahead so downstream strobes can be registered.
module phase_timer
  import pixel_array_pkg::*;
(
  input  logic               clk,
  input  logic               reset,
  input  logic               load,
  input  logic [TIMER_W-1:0] len,
  output logic               last,
  output logic               last_next
);

  logic [TIMER_W-1:0] cnt;

  always_ff @(posedge clk) begin
    if (reset) begin
      cnt <= '0;
    end else if (load) begin
      cnt <= (len == '0) ? '0 : len - TIMER_W'(1);
    end else if (cnt != '0) begin
      cnt <= cnt - TIMER_W'(1);
    end
  end

  assign last      = (cnt == '0);
  assign last_next = load ? (len <= TIMER_W'(1)) : (cnt == TIMER_W'(1));

endmodule

// File: rtl/pixel_array_ctrl.sv
// Frame sequencer ERASE -> EXPOSE -> CONVERT -> READ with one dead GAP cycle between phases.
// All outputs registered; start seen at edge N gives erase/busy from edge N+1.
module pixel_array_ctrl
  import pixel_array_pkg::*;
#(
  parameter int PIXEL_ARRAY_HEIGHT = 2,
  parameter int C_ERASE            = 5,
  parameter int C_READ_ROW         = 5,
  parameter int C_CONVERT          = 256
)(
  input  logic                clk,
  input  logic                reset,
  pixel_array_ctrl_if.master  bus
);

  localparam int H     = PIXEL_ARRAY_HEIGHT;
  localparam int ROW_W = row_width(H);
  localparam logic [ROW_W-1:0] ROW_LAST = ROW_W'(H - 1);

  state_t             state_q, state_nxt;
  state_t             next_phase_q, next_phase_nxt;
  logic [ROW_W-1:0]   row_q, row_nxt;
  logic [7:0]         exp_q;
  logic               done_nxt;

  logic               load;
  logic [TIMER_W-1:0] len;
  logic               last;
  logic               last_next;

  logic               erase_q, expose_q, convert_q, row_valid_q, busy_q, frame_done_q;
  logic [H-1:0]       read_q;
  logic [RAMP_W-1:0]  pixel_counter_q;
  logic [ROW_W-1:0]   row_index_q;

  phase_timer u_timer (
    .clk       (clk),
    .reset     (reset),
    .load      (load),
    .len       (len),
    .last      (last),
    .last_next (last_next)
  );

  always_comb begin
    state_nxt      = state_q;
    next_phase_nxt = next_phase_q;
    row_nxt        = row_q;
    done_nxt       = 1'b0;

    case (state_q)
      IDLE: begin
        // frame_done_q is high only in the first IDLE cycle after a completed frame
        if (bus.start || (bus.continuous && frame_done_q)) state_nxt = ERASE;
      end
      ERASE: begin
        if (last) begin
          state_nxt      = GAP;
          next_phase_nxt = EXPOSE;
        end
      end
      GAP: begin
        if (last) state_nxt = next_phase_q;
      end
      EXPOSE: begin
        if (last) begin
          state_nxt      = GAP;
          next_phase_nxt = CONVERT;
        end
      end
      CONVERT: begin
        if (last) begin
          state_nxt      = GAP;
          next_phase_nxt = READ;
        end
      end
      READ: begin
        if (last) begin
          if (row_q == ROW_LAST) begin
            state_nxt = IDLE;
            done_nxt  = 1'b1;
          end else begin
            row_nxt = row_q + ROW_W'(1);
          end
        end
      end
      default: state_nxt = IDLE;
    endcase

    if (bus.abort) begin
      state_nxt = IDLE;
      done_nxt  = 1'b0;
    end

    if ((state_nxt != READ) || (state_q != READ)) row_nxt = '0;

    // Reload on every phase change and on each row boundary inside READ
    load = (state_nxt != state_q) || ((state_q == READ) && (state_nxt == READ) && last);

    case (state_nxt)
      ERASE:   len = TIMER_W'(C_ERASE);
      GAP:     len = TIMER_W'(GAP_LEN);
      EXPOSE:  len = {1'b0, exp_q};
      CONVERT: len = TIMER_W'(C_CONVERT);
      READ:    len = TIMER_W'(C_READ_ROW);
      default: len = TIMER_W'(1);
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q         <= IDLE;
      next_phase_q    <= IDLE;
      row_q           <= '0;
      exp_q           <= 8'd1;
      erase_q         <= 1'b0;
      expose_q        <= 1'b0;
      convert_q       <= 1'b0;
      read_q          <= '0;
      pixel_counter_q <= '0;
      row_valid_q     <= 1'b0;
      row_index_q     <= '0;
      busy_q          <= 1'b0;
      frame_done_q    <= 1'b0;
    end else begin
      state_q      <= state_nxt;
      next_phase_q <= next_phase_nxt;
      row_q        <= row_nxt;
      if ((state_q == IDLE) && (state_nxt == ERASE)) begin
        exp_q <= (bus.expose_cycles == 8'd0) ? 8'd1 : bus.expose_cycles;
      end
      erase_q         <= (state_nxt == ERASE);
      expose_q        <= (state_nxt == EXPOSE);
      convert_q       <= (state_nxt == CONVERT);
      read_q          <= (state_nxt == READ) ? (H'(1) << row_nxt) : '0;
      pixel_counter_q <= ((state_nxt == CONVERT) && (state_q == CONVERT)) ?
                         pixel_counter_q + RAMP_W'(1) : '0;
      row_valid_q     <= (state_nxt == READ) && last_next;
      row_index_q     <= row_nxt;
      busy_q          <= (state_nxt != IDLE);
      frame_done_q    <= done_nxt;
    end
  end

  assign bus.erase         = erase_q;
  assign bus.expose        = expose_q;
  assign bus.convert       = convert_q;
  assign bus.read          = read_q;
  assign bus.pixel_counter = pixel_counter_q;
  assign bus.row_valid     = row_valid_q;
  assign bus.row_index     = row_index_q;
  assign bus.busy          = busy_q;
  assign bus.frame_done    = frame_done_q;

endmodule

// File: tb/tb_pixel_array_ctrl.sv
// Directed bench for pixel_array_ctrl: frame-offset model compared every cycle,
// plus per-frame counts checked against hand-computed values.
module tb_pixel_array_ctrl;
  import pixel_array_pkg::*;

  localparam int H   = 2;
  localparam int CE  = 5;
  localparam int CRR = 5;

  logic clk   = 1'b0;
  logic reset = 1'b1;
  always #5 clk = ~clk;

  pixel_array_ctrl_if #(.PIXEL_ARRAY_HEIGHT(H)) bus ();

  pixel_array_ctrl #(
    .PIXEL_ARRAY_HEIGHT (H),
    .C_ERASE            (CE),
    .C_READ_ROW         (CRR),
    .C_CONVERT          (256)
  ) dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus)
  );

  typedef struct packed {
    logic       erase;
    logic       expose;
    logic       convert;
    logic [1:0] read;
    logic [7:0] pc;
    logic       rv;
    logic       ri;
    logic       busy;
    logic       done;
  } obs_t;

  int n_cmp = 0;
  int n_bad = 0;
  int cyc_no = 0;

  // model: frame progress expressed as offset k from the first ERASE cycle
  bit m_busy = 1'b0;
  bit m_done = 1'b0;
  int m_k = 0;
  int m_e = 1;

  int s_busy, s_erase, s_expose, s_convert, s_r0, s_r1, s_rv, s_done, s_pcmax, s_pcfirst;
  int run_len, idle_len;
  int runs[$];
  int gaps[$];

  function automatic obs_t model_out();
    obs_t o;
    int b1, b2, b3, b4, b5, r;
    o = '0;
    o.done = m_done;
    if (m_busy) begin
      o.busy = 1'b1;
      b1 = CE + 1;
      b2 = b1 + m_e;
      b3 = b2 + 1;
      b4 = b3 + 256;
      b5 = b4 + 1;
      if (m_k < CE) o.erase = 1'b1;
      else if (m_k >= b1 && m_k < b2) o.expose = 1'b1;
      else if (m_k >= b3 && m_k < b4) begin
        o.convert = 1'b1;
        o.pc = 8'(m_k - b3);
      end else if (m_k >= b5) begin
        r = (m_k - b5) / CRR;
        o.read = 2'(1 << r);
        o.ri = 1'(r);
        o.rv = (((m_k - b5) % CRR) == CRR - 1);
      end
    end
    return o;
  endfunction

  function automatic obs_t dut_out();
    obs_t o;
    o.erase   = bus.erase;
    o.expose  = bus.expose;
    o.convert = bus.convert;
    o.read    = bus.read;
    o.pc      = bus.pixel_counter;
    o.rv      = bus.row_valid;
    o.ri      = bus.row_index;
    o.busy    = bus.busy;
    o.done    = bus.frame_done;
    return o;
  endfunction

  task automatic model_step();
    int flen;
    flen = CE + m_e + 259 + H * CRR;
    if (reset || bus.abort) begin
      m_busy = 1'b0;
      m_done = 1'b0;
    end else if (!m_busy) begin
      if (bus.start || (bus.continuous && m_done)) begin
        m_busy = 1'b1;
        m_k = 0;
        m_e = (bus.expose_cycles == 8'd0) ? 1 : int'(bus.expose_cycles);
      end
      m_done = 1'b0;
    end else begin
      m_k++;
      if (m_k == flen) begin
        m_busy = 1'b0;
        m_done = 1'b1;
      end
    end
  endtask

  task automatic check(input string name, input int act, input int exp);
    n_cmp++;
    if (act != exp) begin
      n_bad++;
      $display("FAIL %s: got %0d expected %0d", name, act, exp);
    end
  endtask

  task automatic clear_stats();
    s_busy = 0; s_erase = 0; s_expose = 0; s_convert = 0; s_r0 = 0; s_r1 = 0;
    s_rv = 0; s_done = 0; s_pcmax = -1; s_pcfirst = -1;
    run_len = 0; idle_len = 0;
    runs.delete();
    gaps.delete();
  endtask

  // one clock: advance the model at the edge, compare on the falling edge
  task automatic cyc();
    obs_t a, e;
    @(posedge clk);
    model_step();
    @(negedge clk);
    cyc_no++;
    e = model_out();
    a = dut_out();
    n_cmp++;
    if (a !== e) begin
      n_bad++;
      $display("FAIL outputs cycle %0d: got %h expected %h", cyc_no, a, e);
    end
    if (a.busy) s_busy++;
    if (a.erase) s_erase++;
    if (a.expose) s_expose++;
    if (a.convert) begin
      if (s_convert == 0) s_pcfirst = int'(a.pc);
      s_convert++;
      if (int'(a.pc) > s_pcmax) s_pcmax = int'(a.pc);
    end
    if (a.read == 2'b01) s_r0++;
    if (a.read == 2'b10) s_r1++;
    if (a.rv) s_rv++;
    if (a.done) s_done++;
    if (a.busy) begin
      if (run_len == 0) begin
        gaps.push_back(idle_len);
        idle_len = 0;
      end
      run_len++;
    end else begin
      if (run_len > 0) runs.push_back(run_len);
      run_len = 0;
      idle_len++;
    end
  endtask

  function automatic int run_at(input int i);
    return (runs.size() > i) ? runs[i] : -1;
  endfunction

  function automatic int gap_at(input int i);
    return (gaps.size() > i) ? gaps[i] : -1;
  endfunction

  initial begin
    obs_t mo;
    bit hit;
    bus.start = 1'b0;
    bus.continuous = 1'b0;
    bus.abort = 1'b0;
    bus.expose_cycles = 8'd0;
    clear_stats();

    repeat (3) cyc();
    reset = 1'b0;
    clear_stats();
    repeat (10) cyc();
    check("reset_outputs", int'(dut_out()), 0);
    check("idle_busy", s_busy, 0);

    // single frame, exposure 10
    clear_stats();
    bus.expose_cycles = 8'd10;
    bus.start = 1'b1;
    cyc();
    bus.start = 1'b0;
    repeat (290) cyc();
    check("f1_busy", s_busy, 284);
    check("f1_run", run_at(0), 284);
    check("f1_erase", s_erase, 5);
    check("f1_expose", s_expose, 10);
    check("f1_convert", s_convert, 256);
    check("f1_pc_first", s_pcfirst, 0);
    check("f1_pc_max", s_pcmax, 255);
    check("f1_read_row0", s_r0, 5);
    check("f1_read_row1", s_r1, 5);
    check("f1_row_valid", s_rv, 2);
    check("f1_done", s_done, 1);

    // exposure 0 behaves as 1; mid-frame setting change and start are ignored
    clear_stats();
    bus.expose_cycles = 8'd0;
    bus.start = 1'b1;
    cyc();
    bus.start = 1'b0;
    repeat (20) cyc();
    bus.expose_cycles = 8'd50;
    bus.start = 1'b1;
    cyc();
    bus.start = 1'b0;
    repeat (270) cyc();
    check("e0_expose", s_expose, 1);
    check("e0_run", run_at(0), 275);
    check("e0_runs", runs.size(), 1);
    check("e0_done", s_done, 1);

    // continuous: three back-to-back frames
    clear_stats();
    bus.expose_cycles = 8'd10;
    bus.continuous = 1'b1;
    bus.start = 1'b1;
    cyc();
    bus.start = 1'b0;
    repeat (670) cyc();
    bus.continuous = 1'b0;
    repeat (300) cyc();
    check("cont_runs", runs.size(), 3);
    check("cont_run0", run_at(0), 284);
    check("cont_run1", run_at(1), 284);
    check("cont_run2", run_at(2), 284);
    check("cont_gap1", gap_at(1), 1);
    check("cont_gap2", gap_at(2), 1);
    check("cont_done", s_done, 3);

    // abort in CONVERT at ramp value 100; continuous must not restart
    clear_stats();
    bus.continuous = 1'b1;
    bus.start = 1'b1;
    cyc();
    bus.start = 1'b0;
    hit = 1'b0;
    for (int i = 0; i < 400 && !hit; i++) begin
      mo = model_out();
      if (mo.convert && mo.pc == 8'd100) hit = 1'b1;
      else cyc();
    end
    check("abort_reached", int'(hit), 1);
    bus.abort = 1'b1;
    cyc();
    bus.abort = 1'b0;
    check("abort_outputs", int'(dut_out()), 0);
    repeat (20) cyc();
    check("abort_run", run_at(0), 118);
    check("abort_runs", runs.size(), 1);
    check("abort_done", s_done, 0);

    // reset during READ row 1
    clear_stats();
    bus.start = 1'b1;
    cyc();
    bus.start = 1'b0;
    hit = 1'b0;
    for (int i = 0; i < 400 && !hit; i++) begin
      mo = model_out();
      if (mo.read == 2'b10) hit = 1'b1;
      else cyc();
    end
    check("rst_reached", int'(hit), 1);
    reset = 1'b1;
    cyc();
    reset = 1'b0;
    check("rst_outputs", int'(dut_out()), 0);
    repeat (20) cyc();
    check("rst_run", run_at(0), 280);
    check("rst_done", s_done, 0);

    // start together with abort in IDLE
    clear_stats();
    bus.continuous = 1'b0;
    bus.start = 1'b1;
    bus.abort = 1'b1;
    cyc();
    bus.start = 1'b0;
    bus.abort = 1'b0;
    check("sa_busy_now", int'(bus.busy), 0);
    repeat (5) cyc();
    check("sa_busy", s_busy, 0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule

// File: doc/pixel_array_ctrl.md
# pixel_array_ctrl

Synthesizable sequencer for the pixel array macro. It drives the per-frame phases ERASE → EXPOSE → CONVERT → READ, producing the array's erase/expose/read controls, the 8-bit digital ramp count used during conversion, and per-row readout strobes. It sits between the frame-level host logic (start/abort, exposure setting) and the PIXEL_ARRAY instance.

## Interface
- PIXEL_ARRAY_HEIGHT, 2: number of rows; width of the one-hot `read` output.
- C_ERASE, 5: erase phase length in cycles (1..256).
- C_READ_ROW, 5: cycles each row's `read` bit is held (1..256).
- C_CONVERT, 256: convert phase length in cycles; fixed at 256 for a full 8-bit ramp.

- clk  in  1  system clock; all logic on posedge.
- reset  in  1  synchronous, active-high.
- start  in  1  frame request; sampled only in IDLE.
- continuous  in  1  when high, a new frame starts automatically after frame_done.
- abort  in  1  synchronous frame abort.
- expose_cycles  in  8  exposure length in cycles; latched at frame start; 0 is treated as 1.
- erase  out  1  pixel erase control.
- expose  out  1  pixel expose control; also gates the analog bias clock externally.
- convert  out  1  conversion active; also gates the analog ramp externally.
- read  out  PIXEL_ARRAY_HEIGHT  one-hot row select.
- pixel_counter  out  8  digital ramp value driven to the array COUNTER input.
- row_valid  out  1  one-cycle pulse on the last cycle of each row read.
- row_index  out  $clog2(PIXEL_ARRAY_HEIGHT)  row currently selected; valid while `read` is nonzero.
- busy  out  1  high in every state except IDLE.
- frame_done  out  1  one-cycle pulse when a frame completes.

## Operation
- States: IDLE, ERASE, GAP, EXPOSE, CONVERT, READ.
- GAP is one dead cycle with all controls low. It sits between ERASE/EXPOSE, EXPOSE/CONVERT and CONVERT/READ. A `next_phase` register selects the state that follows GAP.
- In IDLE, `start=1` or (`continuous=1` and a frame just completed) moves to ERASE and latches `expose_cycles`.
- Each phase lasts exactly its programmed length in cycles: ERASE C_ERASE, EXPOSE latched value, CONVERT 256, READ PIXEL_ARRAY_HEIGHT×C_READ_ROW.
- CONVERT: `pixel_counter` = 0 on the first convert cycle and increments by 1 each cycle, reaching 255 on the last. It is 0 in all other states and never wraps inside the phase.
- READ: the row starts at 0 with `read` = 1 (bit 0). After C_READ_ROW cycles, `read` shifts left and `row_index` increments. `row_valid` is high on the final cycle of each row.
- After the final row, go to IDLE and pulse `frame_done` in the first IDLE cycle.
- `start` while busy is ignored. `expose_cycles` changes mid-frame have no effect.
- `abort` has priority over all transitions. The next cycle is IDLE with all outputs 0 and no `frame_done`. `continuous` does not restart after an abort; a fresh `start` is required.
- `abort` and `start` asserted together in IDLE: `abort` wins and the block stays in IDLE.

## Timing
- All outputs are registered and change only on posedge clk.
- Reset values: IDLE; erase, expose, convert, read, pixel_counter, row_valid, row_index, busy, frame_done all 0; latched exposure 1.
- Latency from `start` to outputs:
  - `start` seen at edge N → state ERASE and `erase`=1, `busy`=1 from edge N+1.
  - Phase with length L occupies edges N+1 … N+L; GAP follows at N+L+1.
- Frame length in busy cycles: C_ERASE + 1 + E + 1 + 256 + 1 + H×C_READ_ROW, where E is the latched exposure and H is PIXEL_ARRAY_HEIGHT.
- `frame_done` coincides with `busy` falling. With `continuous`=1, ERASE begins on the cycle after `frame_done`.
- `reset` mid-frame behaves like `abort` and additionally restores the reset values.

## Structure
- Package `pixel_array_pkg`: the state enum, the GAP length constant (1), and the ramp width (8).
- Sub-module `phase_timer`:
  - Loadable down-counter, 9 bits.
  - Inputs: `load` and `len`.
  - Output: `last`, high on the final cycle of the phase.
  - Used for every phase and for the per-row count inside READ.
- Target size: 150–250 lines of RTL.

## Test plan
All scenarios use H=2, C_ERASE=5, C_READ_ROW=5.
- Reset then idle: all outputs 0 for 10 cycles with `start`=0.
- Single frame, `expose_cycles`=10, one-cycle `start`:
  - `erase` high for 5 cycles, 1 gap, `expose` high for 10 cycles, 1 gap, `convert` high for 256 cycles with `pixel_counter` 0→255, 1 gap.
  - `read`=2'b01 for 5 cycles, then 2'b10 for 5 cycles; `row_valid` pulses at row 0 and row 1.
  - `busy` high for 284 cycles, then `frame_done` for 1 cycle.
- `expose_cycles`=0: expose lasts 1 cycle. Changing `expose_cycles` to 50 mid-frame does not alter the current frame.
- `continuous`=1: ERASE restarts on the cycle after `frame_done`; three back-to-back frames each produce exactly 284 busy cycles.
- `abort` during CONVERT at `pixel_counter`=100: next cycle is IDLE with all outputs 0 and no `frame_done`. `reset` asserted in READ gives the same result.
- Ignored inputs: `start` pulses while busy are ignored. `start` and `abort` together in IDLE keep the block in IDLE.
